scan_sel_gen: RTL and testbench

Sequential select generator feeding the 3-to-8 decoder stage (`dec3to8_*`). It produces the decoder's 3-bit `in` and 1-bit `en`, stepping through all eight select codes at a programmable dwell rate. It supports continuous scanning and single-pass operation. Its outputs connect directly to the decoder's `in`/`en` ports, and the decoder's one-hot `out` drives the LED/digit lines.

---
 rtl/scan_sel_pkg.sv | 23 ++
 rtl/scan_prescaler.sv | 30 +++
 rtl/scan_sel_gen.sv | 97 +++++++++
 tb/tb_scan_sel_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_sel_pkg.sv
// Shared types, constants and code helpers for the scan select generator.
package scan_sel_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SEL_W   = 3;
    localparam int NUM_SEL = 8;

    localparam logic [SEL_W-1:0] SEL_FIRST_UP = '0;
    localparam logic [SEL_W-1:0] SEL_LAST_UP  = SEL_W'(NUM_SEL - 1);

    function automatic logic [SEL_W-1:0] first_code(input logic down);
        return down ? SEL_LAST_UP : SEL_FIRST_UP;
    endfunction

    function automatic logic [SEL_W-1:0] last_code(input logic down);
        return down ? SEL_FIRST_UP : SEL_LAST_UP;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler: counts 0..DIV-1 while running and flags the final count as a tick.
module scan_prescaler #(
    parameter int DIV   = 4,
    parameter int DIV_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/scan_sel_gen.sv
// Select generator stepping a 3-to-8 decoder through all codes at a DIV-cycle dwell.
// Define SCAN_SEL_GEN_DIR_EN to add the dir port and downward (7->0) scans.
module scan_sel_gen
    import scan_sel_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
`ifdef SCAN_SEL_GEN_DIR_EN
    input  logic             dir,
`endif
    output logic [SEL_W-1:0] out_sel,
    output logic             out_en,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    state_t state;
    logic   mode_q;
    logic   dir_q;
    logic   dir_in;
    logic   running;
    logic   restart;
    logic   tick;

`ifdef SCAN_SEL_GEN_DIR_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    assign running = (state == RUN);
    // stop dominates start, so only an unopposed start clears the dwell count
    assign restart = start && !stop;

    scan_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .run  (running),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_sel <= '0;
            out_en  <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                out_sel <= '0;
                out_en  <= 1'b0;
                busy    <= 1'b0;
            end else if (start) begin
                state   <= RUN;
                out_sel <= first_code(dir_in);
                out_en  <= 1'b1;
                busy    <= 1'b1;
                mode_q  <= mode;
                dir_q   <= dir_in;
            end else if (running && tick) begin
                if (out_sel == last_code(dir_q)) begin
                    if (mode_q) begin
                        state   <= IDLE;
                        out_sel <= '0;
                        out_en  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        out_sel <= first_code(dir_q);
                        wrap    <= 1'b1;
                    end
                end else begin
                    out_sel <= dir_q ? out_sel - SEL_W'(1) : out_sel + SEL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: three DUTs (DIV=4,2,1) on shared stimulus, checked every cycle
// against an elapsed-time model, plus directed literal checks.
module tb_scan_sel_gen;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic mode  = 1'b0;
    logic dir   = 1'b0;
    logic dir_eff;

    logic [2:0] sel  [3];
    logic       en   [3];
    logic       busy [3];
    logic       wrap [3];
    logic       done [3];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

`ifdef SCAN_SEL_GEN_DIR_EN
    assign dir_eff = dir;
`else
    assign dir_eff = 1'b0;
`endif

    scan_sel_gen #(.DIV(4), .DIV_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
`ifdef SCAN_SEL_GEN_DIR_EN
        .dir(dir),
`endif
        .out_sel(sel[0]), .out_en(en[0]), .busy(busy[0]), .wrap(wrap[0]), .done(done[0])
    );

    scan_sel_gen #(.DIV(2), .DIV_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
`ifdef SCAN_SEL_GEN_DIR_EN
        .dir(dir),
`endif
        .out_sel(sel[1]), .out_en(en[1]), .busy(busy[1]), .wrap(wrap[1]), .done(done[1])
    );

    scan_sel_gen #(.DIV(1), .DIV_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
`ifdef SCAN_SEL_GEN_DIR_EN
        .dir(dir),
`endif
        .out_sel(sel[2]), .out_en(en[2]), .busy(busy[2]), .wrap(wrap[2]), .done(done[2])
    );

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    endtask

    // Model: a scan is a count of cycles elapsed since its first code appeared.
    int m_el   [3];
    bit m_run  [3];
    bit m_mode [3];
    bit m_dir  [3];
    bit m_wrap [3];
    bit m_done [3];

    function automatic int div_of(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_sel(input int k);
        int code;
        if (!m_run[k]) return 0;
        code = m_el[k] / div_of(k);
        return m_dir[k] ? 7 - code : code;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_el[k] = 0; m_run[k] = 0; m_mode[k] = 0; m_dir[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            m_wrap[k] = 1'b0;
            m_done[k] = 1'b0;
            if (rst) begin
                m_run[k] = 0; m_el[k] = 0; m_mode[k] = 0; m_dir[k] = 0;
            end else if (stop) begin
                m_run[k] = 0; m_el[k] = 0;
            end else if (start) begin
                m_run[k] = 1; m_el[k] = 0; m_mode[k] = mode; m_dir[k] = dir_eff;
            end else if (m_run[k]) begin
                m_el[k]++;
                if (m_el[k] == 8 * div_of(k)) begin
                    m_el[k] = 0;
                    if (m_mode[k]) begin
                        m_run[k]  = 0;
                        m_done[k] = 1;
                    end else begin
                        m_wrap[k] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model_sel[%0d]", k),  int'(sel[k]),  exp_sel(k));
                check($sformatf("model_en[%0d]", k),   int'(en[k]),   int'(m_run[k]));
                check($sformatf("model_busy[%0d]", k), int'(busy[k]), int'(m_run[k]));
                check($sformatf("model_wrap[%0d]", k), int'(wrap[k]), int'(m_wrap[k]));
                check($sformatf("model_done[%0d]", k), int'(done[k]), int'(m_done[k]));
            end
        end
    end

    task automatic pulse_start(input logic m, input logic d);
        mode  = m;
        dir   = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sel0(input int code, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (int'(sel[0]) == code) found = 1'b1;
            else @(negedge clk);
        end
        check(name, int'(found), 1);
    endtask

    initial begin
        int  en_cnt [3];
        int  done_cnt;
        int  wraps  [3];
        logic down;
        logic [7:0] dec;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("reset_sel", int'(sel[0]), 0);
        check("reset_en", int'(en[0]), 0);
        check("reset_busy", int'(busy[0]), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single pass: 8 codes x DIV cycles of out_en, then one done pulse
        for (int k = 0; k < 3; k++) en_cnt[k] = 0;
        done_cnt = 0;
        pulse_start(1'b1, 1'b0);
        check("pass_first_code", int'(sel[0]), 0);
        for (int i = 0; i <= 40; i++) begin
            if (i == 4) check("pass_second_code", int'(sel[0]), 1);
            for (int k = 0; k < 3; k++) if (en[k]) en_cnt[k]++;
            if (done[0]) done_cnt++;
            @(negedge clk);
        end
        check("pass_en_cycles_div4", en_cnt[0], 32);
        check("pass_en_cycles_div2", en_cnt[1], 16);
        check("pass_en_cycles_div1", en_cnt[2], 8);
        check("pass_done_pulses", done_cnt, 1);

        // Continuous: wrap every 8*DIV cycles, coincident with code 0
        for (int k = 0; k < 3; k++) wraps[k] = 0;
        done_cnt = 0;
        pulse_start(1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (wrap[k]) wraps[k]++;
            if (wrap[1]) check("wrap_at_code0", int'(sel[1]), 0);
            if (done[1]) done_cnt++;
        end
        check("cont_wraps_div2", wraps[1], 2);
        check("cont_wraps_div4", wraps[0], 1);
        check("cont_wraps_div1", wraps[2], 5);
        check("cont_no_done", done_cnt, 0);

        // Reset mid-scan at code 5
        wait_sel0(5, "wait_code5");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_sel", int'(sel[0]), 0);
        check("midreset_en", int'(en[0]), 0);
        check("midreset_busy", int'(busy[0]), 0);
        check("midreset_wrap", int'(wrap[0]), 0);
        check("midreset_done", int'(done[0]), 0);

        // Stop at code 3, then a fresh start resumes at code 0
        pulse_start(1'b0, 1'b0);
        wait_sel0(3, "wait_code3");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_en", int'(en[0]), 0);
        check("stop_no_done", int'(done[0]), 0);
        check("stop_sel", int'(sel[0]), 0);
        repeat (3) @(negedge clk);
        pulse_start(1'b0, 1'b0);
        check("resume_sel", int'(sel[0]), 0);
        check("resume_en", int'(en[0]), 1);

        // start+stop together while running: stop wins
        repeat (5) @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_en_div4", int'(en[0]), 0);
        check("startstop_en_div1", int'(en[2]), 0);

        // start alone at code 6 restarts the scan and the dwell count
        pulse_start(1'b0, 1'b0);
        wait_sel0(6, "wait_code6");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_sel", int'(sel[0]), 0);
        check("restart_no_wrap", int'(wrap[0]), 0);
        repeat (3) @(negedge clk);
        check("restart_hold", int'(sel[0]), 0);
        @(negedge clk);
        check("restart_step", int'(sel[0]), 1);

        // DIV=1 single pass: one code per cycle; decoder walks 7..0 when scanning down
`ifdef SCAN_SEL_GEN_DIR_EN
        down = 1'b1;
`else
        down = 1'b0;
`endif
        pulse_start(1'b1, down);
        for (int i = 0; i < 8; i++) begin
            dec = 8'b1 << sel[2];
            check($sformatf("div1_sel_%0d", i), int'(sel[2]), down ? 7 - i : i);
            check($sformatf("div1_dec_%0d", i), int'(dec), down ? int'(8'h80 >> i) : int'(8'h01 << i));
            @(negedge clk);
        end
        check("div1_done", int'(done[2]), 1);
        check("div1_en_off", int'(en[2]), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 89) == 0);
            rst   = ($urandom_range(0, 399) == 0);
            mode  = 1'($urandom_range(0, 1));
            dir   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
